// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tape_pkg
//  Description : Shared types and encodings for the cassette tape transport
//                sequencer: transport states, CPU command codes, defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package tape_pkg;

  localparam int POS_W_DEF = 24;

  // Transport state; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPINUP = 3'd1,
    ST_PLAY   = 3'd2,
    ST_FF     = 3'd3,
    ST_REW    = 3'd4
  } tape_state_e;

  // CPU command codes; 6 and 7 are reserved and always rejected.
  localparam logic [2:0] CMD_STOP     = 3'd0;
  localparam logic [2:0] CMD_PLAY     = 3'd1;
  localparam logic [2:0] CMD_FF       = 3'd2;
  localparam logic [2:0] CMD_REW      = 3'd3;
  localparam logic [2:0] CMD_LOAD_END = 3'd4;
  localparam logic [2:0] CMD_SEEK     = 3'd5;

  // Run state selected by a PLAY/FF/REW command code.
  function automatic tape_state_e run_state(input logic [2:0] c);
    case (c)
      CMD_PLAY: return ST_PLAY;
      CMD_FF:   return ST_FF;
      default:  return ST_REW;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tape_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tape_prescaler
//  Description : ce-gated counter with a runtime modulus. tick_o is high on
//                the ce where the count sits at modulus-1; the count then
//                wraps to zero. clr_i restarts the count synchronously.
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_prescaler #(
  parameter int CNT_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] mod_i,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  assign last   = (cnt_q == (mod_i - C_ONE));
  assign tick_o = ce_i & last;

  // Next count: clear wins, otherwise advance on ce and wrap at the modulus.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ce_i) begin
      cnt_d = last ? '0 : (cnt_q + C_ONE);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tape_transport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tape_transport_ctrl
//  Description : Cassette transport sequencer. Accepts STOP/PLAY/FF/REW/
//                LOAD_END/SEEK commands, runs a motor spin-up delay, paces
//                position steps from a ce prescaler and stops (or wraps in
//                loop mode) at the tape ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_transport_ctrl
  import tape_pkg::*;
#(
  parameter int POS_W         = POS_W_DEF,
  parameter int DIV_PLAY      = 6667,
  parameter int DIV_WIND      = 834,
  parameter int SPIN_TICKS    = 4096,
  parameter int TAPE_END_INIT = 1023,
  parameter int LOOP          = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [POS_W-1:0] cmd_data,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] tape_end,
  output logic [2:0]       state,
  output logic             motor,
  output logic             step,
  output logic             at_start,
  output logic             at_end,
  output logic             cmd_err
);

  localparam int               CNT_W     = $clog2(max3(DIV_PLAY, DIV_WIND, SPIN_TICKS) + 1);
  localparam logic [CNT_W-1:0] MOD_PLAY  = CNT_W'(DIV_PLAY);
  localparam logic [CNT_W-1:0] MOD_WIND  = CNT_W'(DIV_WIND);
  localparam logic [CNT_W-1:0] MOD_SPIN  = CNT_W'(SPIN_TICKS);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] TEND_INIT = POS_W'(TAPE_END_INIT);

  tape_state_e      state_q, state_d;
  tape_state_e      target_q, target_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] tend_q, tend_d;
  logic             ready_q, ready_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  logic             accept;
  logic             tick;
  logic             presc_clr;
  logic [CNT_W-1:0] presc_mod;
  logic             pos_at_start;
  logic             pos_at_end;
  logic             run_reject;
  tape_state_e      run_req;

  assign accept       = cmd_valid & ready_q;
  assign pos_at_start = (pos_q == '0);
  assign pos_at_end   = (pos_q == tend_q);
  assign run_req      = run_state(cmd);

  // A run command from IDLE is refused if it would have nowhere to go.
  assign run_reject = ((run_req == ST_PLAY) && (LOOP == 0) && pos_at_end) ||
                      ((run_req == ST_FF) && pos_at_end) ||
                      ((run_req == ST_REW) && pos_at_start);

  // Pacing modulus for the current state (IDLE keeps the counter cleared).
  always_comb begin
    presc_mod = MOD_SPIN;
    case (state_q)
      ST_PLAY:       presc_mod = MOD_PLAY;
      ST_FF, ST_REW: presc_mod = MOD_WIND;
      default:       presc_mod = MOD_SPIN;
    endcase
  end

  assign presc_clr = (state_d != state_q) || (state_q == ST_IDLE);

  tape_prescaler #(
    .CNT_W (CNT_W)
  ) u_presc (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .ce_i   (ce),
    .clr_i  (presc_clr),
    .mod_i  (presc_mod),
    .tick_o (tick)
  );

  // Next-state logic: an accepted command takes priority over a pacing tick.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pos_d    = pos_q;
    tend_d   = tend_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    ready_d  = ~accept;

    if (accept) begin
      case (cmd)
        CMD_STOP: state_d = ST_IDLE;
        CMD_PLAY, CMD_FF, CMD_REW: begin
          if (state_q == ST_IDLE) begin
            if (run_reject) begin
              err_d = 1'b1;
            end else begin
              state_d  = ST_SPINUP;
              target_d = run_req;
            end
          end else if (state_q == ST_SPINUP) begin
            // Retarget while the motor keeps spinning up.
            target_d = run_req;
          end else begin
            state_d = run_req;
          end
        end
        CMD_LOAD_END: begin
          if (state_q == ST_IDLE) begin
            tend_d = cmd_data;
            if (pos_q > cmd_data) pos_d = cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_SEEK: begin
          if (state_q == ST_IDLE) begin
            pos_d = (cmd_data > tend_q) ? tend_q : cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_SPINUP: state_d = target_q;
        ST_PLAY: begin
          if (pos_at_end) begin
            if (LOOP != 0) begin
              pos_d  = '0;
              step_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            pos_d  = pos_q + POS_ONE;
            step_d = 1'b1;
          end
        end
        ST_FF: begin
          // Guarded: FF may be entered directly while already at the end.
          if (pos_at_end) begin
            state_d = ST_IDLE;
          end else begin
            pos_d = pos_q + POS_ONE;
            if ((pos_q + POS_ONE) == tend_q) state_d = ST_IDLE;
          end
        end
        ST_REW: begin
          if (pos_at_start) begin
            state_d = ST_IDLE;
          end else begin
            pos_d = pos_q - POS_ONE;
            if (pos_q == POS_ONE) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, position and handshake registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= ST_PLAY;
      pos_q    <= '0;
      tend_q   <= TEND_INIT;
      ready_q  <= 1'b1;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pos_q    <= pos_d;
      tend_q   <= tend_d;
      ready_q  <= ready_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign pos       = pos_q;
  assign tape_end  = tend_q;
  assign state     = state_q;
  assign motor     = (state_q != ST_IDLE);
  assign step      = step_q;
  assign cmd_err   = err_q;
  assign at_start  = pos_at_start;
  assign at_end    = pos_at_end;

endmodule
`default_nettype wire

// File: tb/tb_tape_transport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tape_transport_ctrl
//  Description : Bench for tape_transport_ctrl. Two instances share stimulus,
//                one stopping at the tape end and one wrapping (loop mode),
//                each compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_transport_ctrl;

  localparam int PW   = 24;
  localparam int SPIN = 4;
  localparam int DIVP = 3;
  localparam int DIVW = 2;
  localparam int TEND = 1023;

  logic          clk_sys = 1'b0;
  logic          reset_r = 1'b1;
  logic          ce_r    = 1'b1;
  logic          valid_r = 1'b0;
  logic [2:0]    cmd_r   = 3'd0;
  logic [PW-1:0] data_r  = '0;

  logic          rdy   [2];
  logic [PW-1:0] posv  [2];
  logic [PW-1:0] tendv [2];
  logic [2:0]    st    [2];
  logic          mot   [2];
  logic          stp   [2];
  logic          ast   [2];
  logic          aen   [2];
  logic          err   [2];

  int total = 0;
  int bad   = 0;

  // Reference model: one record per instance, holding the post-edge view.
  int          m_mode [2];
  int          m_tgt  [2];
  int          m_ce   [2];
  int unsigned m_pos  [2];
  int unsigned m_tend [2];
  bit          m_rdy  [2];
  bit          m_step [2];
  bit          m_err  [2];

  always #5 clk_sys = ~clk_sys;

  tape_transport_ctrl #(
    .POS_W(PW), .DIV_PLAY(DIVP), .DIV_WIND(DIVW), .SPIN_TICKS(SPIN),
    .TAPE_END_INIT(TEND), .LOOP(0)
  ) u_dut0 (
    .clk_sys(clk_sys), .reset(reset_r), .ce(ce_r), .cmd_valid(valid_r),
    .cmd_ready(rdy[0]), .cmd(cmd_r), .cmd_data(data_r), .pos(posv[0]),
    .tape_end(tendv[0]), .state(st[0]), .motor(mot[0]), .step(stp[0]),
    .at_start(ast[0]), .at_end(aen[0]), .cmd_err(err[0])
  );

  tape_transport_ctrl #(
    .POS_W(PW), .DIV_PLAY(DIVP), .DIV_WIND(DIVW), .SPIN_TICKS(SPIN),
    .TAPE_END_INIT(TEND), .LOOP(1)
  ) u_dut1 (
    .clk_sys(clk_sys), .reset(reset_r), .ce(ce_r), .cmd_valid(valid_r),
    .cmd_ready(rdy[1]), .cmd(cmd_r), .cmd_data(data_r), .pos(posv[1]),
    .tape_end(tendv[1]), .state(st[1]), .motor(mot[1]), .step(stp[1]),
    .at_start(ast[1]), .at_end(aen[1]), .cmd_err(err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model of instance k by one clock using the current inputs.
  task automatic model_step(input int k);
    int          mode, nmode, div, run;
    int unsigned p, te;
    bit          acc, tk, loop_mode;
    loop_mode = (k == 1);
    if (reset_r) begin
      m_mode[k] = 0; m_tgt[k] = 2; m_ce[k] = 0; m_pos[k] = 0;
      m_tend[k] = TEND; m_rdy[k] = 1; m_step[k] = 0; m_err[k] = 0;
      return;
    end
    mode = m_mode[k]; p = m_pos[k]; te = m_tend[k];
    acc  = valid_r && m_rdy[k];
    div  = (mode == 1) ? SPIN : (mode == 2) ? DIVP : DIVW;
    tk   = ce_r && (mode != 0) && ((m_ce[k] % div) == div - 1);
    if (ce_r && mode != 0) m_ce[k]++;
    nmode = mode;
    m_step[k] = 0; m_err[k] = 0; m_rdy[k] = !acc;
    if (acc) begin
      case (int'(cmd_r))
        0: nmode = 0;
        1, 2, 3: begin
          run = int'(cmd_r) + 1;
          if (mode == 0) begin
            if ((run == 2 && !loop_mode && p == te) || (run == 3 && p == te) ||
                (run == 4 && p == 0)) begin
              m_err[k] = 1;
            end else begin
              nmode = 1; m_tgt[k] = run;
            end
          end else if (mode == 1) m_tgt[k] = run;
          else nmode = run;
        end
        4: if (mode == 0) begin
             m_tend[k] = data_r;
             if (p > data_r) m_pos[k] = data_r;
           end else m_err[k] = 1;
        5: if (mode == 0) m_pos[k] = (data_r > te) ? te : data_r;
           else m_err[k] = 1;
        default: m_err[k] = 1;
      endcase
    end else if (tk) begin
      case (mode)
        1: nmode = m_tgt[k];
        2: if (p == te) begin
             if (loop_mode) begin m_pos[k] = 0; m_step[k] = 1; end
             else nmode = 0;
           end else begin m_pos[k] = p + 1; m_step[k] = 1; end
        3: if (p == te) nmode = 0;
           else begin m_pos[k] = p + 1; if (p + 1 == te) nmode = 0; end
        4: if (p == 0) nmode = 0;
           else begin m_pos[k] = p - 1; if (p == 1) nmode = 0; end
        default: ;
      endcase
    end
    if (nmode != mode || mode == 0) m_ce[k] = 0;
    m_mode[k] = nmode;
  endtask

  task automatic compare_all(input int k);
    check_eq($sformatf("state%0d", k), 32'(st[k]), 32'(m_mode[k]));
    check_eq($sformatf("pos%0d", k), 32'(posv[k]), m_pos[k]);
    check_eq($sformatf("tape_end%0d", k), 32'(tendv[k]), m_tend[k]);
    check_eq($sformatf("motor%0d", k), 32'(mot[k]), 32'(m_mode[k] != 0));
    check_eq($sformatf("step%0d", k), 32'(stp[k]), 32'(m_step[k]));
    check_eq($sformatf("cmd_err%0d", k), 32'(err[k]), 32'(m_err[k]));
    check_eq($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_rdy[k]));
    check_eq($sformatf("at_start%0d", k), 32'(ast[k]), 32'(m_pos[k] == 0));
    check_eq($sformatf("at_end%0d", k), 32'(aen[k]), 32'(m_pos[k] == m_tend[k]));
  endtask

  task automatic run_cycle();
    model_step(0);
    model_step(1);
    @(posedge clk_sys);
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  // Present a command for exactly one accepting edge.
  task automatic send_cmd(input logic [2:0] c, input int unsigned d);
    valid_r = 1'b1; cmd_r = c; data_r = PW'(d);
    run_cycle();
    valid_r = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input int unsigned d);
    send_cmd(c, d);
    run_cycle();
  endtask

  initial begin
    // Reset values
    reset_r = 1'b1;
    run_cycle(); run_cycle();
    reset_r = 1'b0;
    check_eq("rst_state", 32'(st[0]), 0);
    check_eq("rst_pos", 32'(posv[0]), 0);
    check_eq("rst_tend", 32'(tendv[0]), TEND);
    check_eq("rst_ready", 32'(rdy[0]), 1);

    // PLAY spin-up timing with ce every cycle
    ce_r = 1'b1;
    send_cmd(3'd1, 0);
    check_eq("spin_enter", 32'(st[0]), 1);
    check_eq("ready_drop", 32'(rdy[0]), 0);
    repeat (3) run_cycle();
    check_eq("spin_hold", 32'(st[0]), 1);
    run_cycle();
    check_eq("play_enter", 32'(st[0]), 2);
    repeat (2) run_cycle();
    check_eq("pos_before_step", 32'(posv[0]), 0);
    run_cycle();
    check_eq("first_step_pos", 32'(posv[0]), 1);
    check_eq("first_step_pulse", 32'(stp[0]), 1);

    // Stop at tape end, or wrap in loop mode
    issue(3'd0, 0);
    issue(3'd4, 5);
    issue(3'd5, 3);
    issue(3'd1, 0);
    repeat (40) run_cycle();
    check_eq("end_stop_state", 32'(st[0]), 0);
    check_eq("end_stop_pos", 32'(posv[0]), 5);
    check_eq("loop_still_play", 32'(st[1]), 2);
    send_cmd(3'd1, 0);
    check_eq("play_at_end_err", 32'(err[0]), 1);
    run_cycle();

    // Loop wrap with a short tape
    issue(3'd0, 0);
    issue(3'd4, 2);
    issue(3'd5, 0);
    issue(3'd1, 0);
    repeat (30) run_cycle();

    // FF straight from PLAY, then rewind to the start
    issue(3'd0, 0);
    issue(3'd4, 30);
    issue(3'd5, 10);
    issue(3'd1, 0);
    repeat (6) run_cycle();
    send_cmd(3'd2, 0);
    check_eq("ff_direct", 32'(st[0]), 3);
    run_cycle();
    issue(3'd3, 0);
    repeat (60) run_cycle();
    check_eq("rew_idle", 32'(st[0]), 0);
    check_eq("rew_at_start", 32'(ast[0]), 1);
    send_cmd(3'd3, 0);
    check_eq("rew_at_start_err", 32'(err[0]), 1);
    run_cycle();

    // LOAD_END / SEEK clamping, SEEK outside IDLE
    issue(3'd5, 20);
    issue(3'd4, 7);
    check_eq("load_clamp_pos", 32'(posv[0]), 7);
    check_eq("load_tend", 32'(tendv[0]), 7);
    issue(3'd5, 100);
    check_eq("seek_clamp", 32'(posv[0]), 7);
    issue(3'd5, 2);
    issue(3'd1, 0);
    repeat (6) run_cycle();
    send_cmd(3'd5, 0);
    check_eq("seek_busy_err", 32'(err[0]), 1);
    run_cycle();

    // Held STOP accepted every other cycle
    valid_r = 1'b1; cmd_r = 3'd0;
    repeat (10) run_cycle();
    valid_r = 1'b0;
    run_cycle();

    // Reset in the middle of FF
    issue(3'd4, 30);
    issue(3'd2, 0);
    repeat (8) run_cycle();
    reset_r = 1'b1;
    run_cycle();
    reset_r = 1'b0;
    check_eq("midrst_state", 32'(st[0]), 0);
    check_eq("midrst_pos", 32'(posv[0]), 0);
    check_eq("midrst_tend", 32'(tendv[0]), TEND);
    issue(3'd4, 12);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset_r = ($urandom_range(0, 799) == 0);
      ce_r    = ($urandom_range(0, 3) != 0);
      valid_r = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 99);
      cmd_r = (r < 10) ? 3'd0 : (r < 35) ? 3'd1 : (r < 55) ? 3'd2 :
              (r < 75) ? 3'd3 : (r < 85) ? 3'd4 : (r < 95) ? 3'd5 :
              3'($urandom_range(6, 7));
      data_r = PW'($urandom_range(0, 30));
      run_cycle();
    end
    reset_r = 1'b0;
    valid_r = 1'b0;
    run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tape_transport_ctrl.md
# tape_transport_ctrl

Transport sequencer for the cassette tape position shown on the video overlay. Accepts STOP/PLAY/FF/REW/LOAD/SEEK commands from the CPU side, paces position steps from a clock-enable prescaler, and runs a motor spin-up delay. Stops at the tape ends, or wraps at the end in loop mode. Drives the overlay `pos`/`max` inputs and a per-step strobe for the tape data path.

## Interface
- POS_W, 24, position and tape-end width
- DIV_PLAY, 6667, ce ticks per PLAY step
- DIV_WIND, 834, ce ticks per FF/REW step
- SPIN_TICKS, 4096, ce ticks of motor spin-up before the first step
- TAPE_END_INIT, 1023, `tape_end` reset value
- LOOP, 0, 1 = PLAY wraps from `tape_end` to 0 instead of stopping
- clk_sys  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- ce  in  1  pacing enable (pixel-rate strobe in clk_sys domain)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; transfer = valid & ready
- cmd  in  3  0 STOP, 1 PLAY, 2 FF, 3 REW, 4 LOAD_END, 5 SEEK; 6–7 reserved
- cmd_data  in  POS_W  operand for LOAD_END/SEEK
- pos  out  POS_W  current tape position (to overlay `pos`)
- tape_end  out  POS_W  last valid position (to overlay `max`)
- state  out  3  0 IDLE, 1 SPINUP, 2 PLAY, 3 FF, 4 REW
- motor  out  1  high in SPINUP, PLAY, FF, REW
- step  out  1  one-cycle pulse on each PLAY position change
- at_start / at_end  out  1 each  pos==0 / pos==tape_end (combinational from registers)
- cmd_err  out  1  one-cycle pulse when an accepted command is rejected

## Operation
- Reset values: state IDLE, pos 0, tape_end TAPE_END_INIT, motor 0, cmd_ready 1, step 0, cmd_err 0, prescaler 0.
- Prescaler: counts ce ticks and wraps at DIV−1, where DIV is DIV_PLAY, DIV_WIND or SPIN_TICKS by state. A tick event fires on the ce where count==DIV−1. The prescaler clears on every state change.
- Transitions:
  - IDLE + PLAY/FF/REW → SPINUP, with the target latched.
  - SPINUP tick → target state.
  - PLAY/FF/REW + a different run command → that state directly, with no spin-up.
  - Same command as the current state or target → no effect; the prescaler is not cleared.
  - STOP from any state → IDLE.
- PLAY tick: pos+1 and pulse `step`.
  - If pos==tape_end: LOOP=0 → IDLE, no step; LOOP=1 → pos 0 with step.
- FF tick: pos+1. On reaching tape_end → IDLE in the same cycle.
- REW tick: pos−1. On reaching 0 → IDLE in the same cycle.
- Rejections (pulse cmd_err, state unchanged):
  - PLAY from IDLE at tape_end with LOOP=0.
  - FF from IDLE at tape_end.
  - REW from IDLE at pos 0.
  - LOAD_END or SEEK outside IDLE.
  - Reserved codes.
- LOAD_END (IDLE only): tape_end ← cmd_data; pos ← min(pos, cmd_data).
- SEEK (IDLE only): pos ← min(cmd_data, tape_end).
- Simultaneous command acceptance and tick: the command wins and no step is applied that cycle.
- Arithmetic is unsigned POS_W. pos never leaves [0, tape_end].

## Timing
- Handshake:
  - cmd_ready drops the cycle after an acceptance and returns high the next cycle, so at most one command is accepted per 2 cycles.
  - cmd_valid may be held; a held command is accepted again once ready returns.
- Command effects (state, pos, tape_end, cmd_err) are registered and visible the cycle after acceptance.
- PLAY from IDLE with ce=1 every cycle: state=SPINUP at T+1, PLAY at T+1+SPIN_TICKS, first pos change SPIN_TICKS+DIV_PLAY cycles after acceptance.
- step is coincident with the pos update cycle.
- Reset asserted mid-operation returns every output to its reset value on the next edge.

## Structure
- Package tape_pkg holds the state enum, command encodings and the POS_W default.
- Sub-module tape_prescaler: ce-gated counter with a runtime modulus input, synchronous clear, and a one-cycle tick output.
- The FSM, position register and handshake stay in the top module.

## Test plan
- Reset, then PLAY with SPIN_TICKS=4, DIV_PLAY=3, ce=1 → SPINUP 4 cycles, then pos 0→1 three cycles later, step pulse each increment.
- LOOP=0, tape_end=5, PLAY from pos 3 → pos 4, 5, then IDLE, motor 0, no further step; PLAY again → cmd_err, stays IDLE.
- LOOP=1, tape_end=2 → pos sequence 0, 1, 2, 0, 1 with step on every change including the wrap.
- FF during PLAY at pos 10 → state FF immediately with no spin-up; REW run reaches 0 → IDLE, at_start 1; REW again → cmd_err.
- In IDLE, LOAD_END 7 with pos=20 → tape_end 7, pos 7; SEEK 100 → pos 7; SEEK during PLAY → cmd_err, pos unaffected.
- Hold cmd_valid with STOP continuously → accepted every other cycle; assert reset mid-FF → IDLE, pos 0, tape_end 1023 next cycle.
